// File: rtl/mul_pkg.sv
// mul_pkg: shared constants for the 4x4 sequential multiplier and the
// dot-product sequencer built around it.
//   - operand / product widths of seq_mul
//   - default multiplier latency (also used by seq_mul's integration bench)
//   - sequencer state encodings
//   - helper to size the latency down-counter
package mul_pkg;

    localparam int MUL_IN_W    = 4;
    localparam int MUL_OP_W    = 8;
    localparam int MUL_LAT_DEF = 6;

    // Sequencer states, kept as plain constants for legacy tool flows.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_OUT   = 2'd3;

    // Width needed to hold lat-1 (never less than one bit).
    function automatic int tmr_width(input int lat);
        return (lat > 1) ? $clog2(lat) : 1;
    endfunction

endpackage

// File: rtl/lat_timer.sv
// lat_timer: loadable down-counter with a zero flag.
//   clk      in   rising-edge clock
//   reset    in   synchronous active-high reset (counter -> 0)
//   load     in   load load_val this cycle
//   load_val in   W  value to load
//   zero     out  counter currently equals zero
// The counter stops at zero and stays there until the next load.
module lat_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] r_cnt;

    // Count register: load has priority, otherwise decrement down to zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign zero = (r_cnt == '0);

endmodule

// File: rtl/mul_dot_seq.sv
// mul_dot_seq: sequencer + dot-product accumulator around seq_mul.
//   clk, reset            clock, synchronous active-high reset
//   in_valid/in_ready     operand pair handshake (in_a, in_b, in_last)
//   mul_start             one-cycle start pulse to seq_mul
//   mul_a, mul_b          operands held stable for seq_mul
//   mul_op                product from seq_mul, sampled MUL_LAT cycles
//                         after the mul_start cycle
//   out_valid/out_ready   result handshake
//   acc_out               accumulated dot product (saturating)
//   term_cnt              terms in acc_out (saturating)
//   ovf                   sticky: accumulator saturated in this dot product
module mul_dot_seq
    import mul_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int ACC_W   = 12,
    parameter int CNT_W   = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [MUL_IN_W-1:0] in_a,
    input  logic [MUL_IN_W-1:0] in_b,
    input  logic                in_last,
    output logic                mul_start,
    output logic [MUL_IN_W-1:0] mul_a,
    output logic [MUL_IN_W-1:0] mul_b,
    input  logic [MUL_OP_W-1:0] mul_op,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ACC_W-1:0]    acc_out,
    output logic [CNT_W-1:0]    term_cnt,
    output logic                ovf
);

    localparam int TMR_W = tmr_width(MUL_LAT);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(MUL_LAT - 1);

    logic [1:0]          r_state;
    logic                r_last;
    logic                r_in_ready;
    logic                r_mul_start;
    logic [MUL_IN_W-1:0] r_mul_a;
    logic [MUL_IN_W-1:0] r_mul_b;
    logic                r_out_valid;
    logic [ACC_W-1:0]    r_acc;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_ovf;

    logic                w_tmr_load;
    logic                w_tmr_zero;
    logic [ACC_W:0]      w_sum;
    logic [ACC_W-1:0]    w_acc_nxt;
    logic                w_ovf_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;

    // The countdown is armed while in START so WAIT sees MUL_LAT-1 first.
    assign w_tmr_load = (r_state == ST_START);

    lat_timer #(
        .W (TMR_W)
    ) u_lat_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (w_tmr_load),
        .load_val (TMR_LOAD),
        .zero     (w_tmr_zero)
    );

    // One extra bit catches carry out of the accumulator.
    assign w_sum = {1'b0, r_acc} + {{(ACC_W + 1 - MUL_OP_W){1'b0}}, mul_op};

    // Saturating next-values for accumulator, sticky overflow and term count.
    always_comb begin
        w_acc_nxt = w_sum[ACC_W-1:0];
        w_ovf_nxt = r_ovf;
        w_cnt_nxt = r_cnt;
        if (w_sum[ACC_W]) begin
            w_acc_nxt = {ACC_W{1'b1}};
            w_ovf_nxt = 1'b1;
        end else begin
            w_acc_nxt = w_sum[ACC_W-1:0];
            w_ovf_nxt = r_ovf;
        end
        if (r_cnt != {CNT_W{1'b1}}) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end else begin
            w_cnt_nxt = r_cnt;
        end
    end

    // Sequencer FSM; all handshake outputs are registered alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_last      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_mul_start <= 1'b0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_out_valid <= 1'b0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_mul_a     <= in_a;
                        r_mul_b     <= in_b;
                        r_last      <= in_last;
                        r_mul_start <= 1'b1;
                        r_in_ready  <= 1'b0;
                        r_state     <= ST_START;
                    end else begin
                        r_mul_start <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                ST_START: begin
                    r_mul_start <= 1'b0;
                    r_state     <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Product is only valid in the cycle the countdown hits zero.
                    if (w_tmr_zero) begin
                        r_acc <= w_acc_nxt;
                        r_ovf <= w_ovf_nxt;
                        r_cnt <= w_cnt_nxt;
                        if (r_last) begin
                            r_out_valid <= 1'b1;
                            r_state     <= ST_OUT;
                        end else begin
                            r_in_ready <= 1'b1;
                            r_state    <= ST_IDLE;
                        end
                    end else begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        r_acc       <= '0;
                        r_cnt       <= '0;
                        r_ovf       <= 1'b0;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_state <= ST_OUT;
                    end
                end
                default: begin
                    r_mul_start <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign mul_start = r_mul_start;
    assign mul_a     = r_mul_a;
    assign mul_b     = r_mul_b;
    assign out_valid = r_out_valid;
    assign acc_out   = r_acc;
    assign term_cnt  = r_cnt;
    assign ovf       = r_ovf;

endmodule
